// File: rtl/uart_rx_clock_set_from_pc.sv
// Time-set receiver: 16x oversampled UART byte receiver feeding a 5-byte frame
// parser (AA, hour, minute, seconds, xor checksum) that drives the clock set inputs.
module uart_rx_clock_set_from_pc #(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int TIMEOUT_CYC = 5_000_000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [2:0] baud_set,
    input  logic       uart_rx,
    output logic [4:0] Hour,
    output logic [5:0] Minute,
    output logic [5:0] Seconds,
    output logic       set_valid,
    output logic       frame_err
);
    localparam int DIV0 = CLK_FREQ / (9600 * 16);
    localparam int DIV1 = CLK_FREQ / (19200 * 16);
    localparam int DIV2 = CLK_FREQ / (38400 * 16);
    localparam int DIV3 = CLK_FREQ / (57600 * 16);
    localparam int DIV4 = CLK_FREQ / (115200 * 16);
    localparam int DW   = $clog2(DIV0 + 1);
    localparam int TW   = $clog2(TIMEOUT_CYC + 1);

    function automatic logic [DW-1:0] div_for(input logic [2:0] sel);
        case (sel)
            3'd0:    return DW'(DIV0);
            3'd1:    return DW'(DIV1);
            3'd2:    return DW'(DIV2);
            3'd3:    return DW'(DIV3);
            default: return DW'(DIV4);
        endcase
    endfunction

    logic rx_meta, rx;
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rx_meta <= 1'b1;
            rx      <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx      <= rx_meta;
        end
    end

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
    rx_state_t rx_state, rx_next;

    logic [DW-1:0] div, clk_cnt;
    logic [4:0]    tick_cnt, tick_num;
    logic [2:0]    bit_idx;
    logic [1:0]    votes;
    logic [7:0]    shreg;
    logic          tick, maj, byte_ok, byte_ferr;

    // tick_num is the 1-based index of the tick firing this cycle within the bit
    assign tick     = (rx_state != IDLE) && (clk_cnt == div - 1'b1);
    assign tick_num = tick_cnt + 5'd1;
    assign maj      = (votes + {1'b0, rx}) >= 2'd2;

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            IDLE:  if (!rx) rx_next = START;
            START: if (tick && tick_num == 5'd8 && rx) rx_next = IDLE;
                   else if (tick && tick_num == 5'd16) rx_next = DATA;
            DATA:  if (tick && tick_num == 5'd16 && bit_idx == 3'd7) rx_next = STOP;
            STOP:  if (tick && tick_num == 5'd9) rx_next = IDLE;
            default: rx_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) rx_state <= IDLE;
        else       rx_state <= rx_next;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            div       <= DW'(DIV4);
            clk_cnt   <= '0;
            tick_cnt  <= '0;
            bit_idx   <= '0;
            votes     <= '0;
            shreg     <= '0;
            byte_ok   <= 1'b0;
            byte_ferr <= 1'b0;
        end else begin
            byte_ok   <= 1'b0;
            byte_ferr <= 1'b0;
            if (rx_state == IDLE) begin
                div      <= div_for(baud_set);
                clk_cnt  <= '0;
                tick_cnt <= '0;
                bit_idx  <= '0;
                votes    <= '0;
            end else if (tick) begin
                clk_cnt  <= '0;
                tick_cnt <= (tick_num == 5'd16) ? 5'd0 : tick_num;
                if (tick_num == 5'd7 || tick_num == 5'd8) votes <= votes + {1'b0, rx};
                if (tick_num == 5'd16) votes <= '0;
                if (rx_state == DATA && tick_num == 5'd9)  shreg   <= {maj, shreg[7:1]};
                if (rx_state == DATA && tick_num == 5'd16) bit_idx <= bit_idx + 3'd1;
                if (rx_state == STOP && tick_num == 5'd9) begin
                    byte_ok   <= maj;
                    byte_ferr <= !maj;
                end
            end else begin
                clk_cnt <= clk_cnt + 1'b1;
            end
        end
    end

    typedef enum logic [2:0] {W_HDR, W_H, W_M, W_S, W_CK} ps_t;
    ps_t ps, ps_next;

    logic [7:0]    sh_h, sh_m, sh_s;
    logic [TW-1:0] idle_cnt;
    logic          timeout, frame_ok, accept, reject;

    // idle_cnt counts cycles since the last byte event, the event cycle itself being 1
    assign timeout  = (ps != W_HDR) && !byte_ok && !byte_ferr &&
                      (idle_cnt >= TW'(TIMEOUT_CYC - 1));
    assign frame_ok = (shreg == (sh_h ^ sh_m ^ sh_s)) &&
                      (sh_h <= 8'd23) && (sh_m <= 8'd59) && (sh_s <= 8'd59);

    always_comb begin
        ps_next = ps;
        accept  = 1'b0;
        reject  = 1'b0;
        if (byte_ferr) begin
            if (ps != W_HDR) begin
                ps_next = W_HDR;
                reject  = 1'b1;
            end
        end else if (byte_ok) begin
            case (ps)
                W_HDR:   if (shreg == 8'hAA) ps_next = W_H;
                W_H:     ps_next = W_M;
                W_M:     ps_next = W_S;
                W_S:     ps_next = W_CK;
                W_CK: begin
                    ps_next = W_HDR;
                    accept  = frame_ok;
                    reject  = !frame_ok;
                end
                default: ps_next = W_HDR;
            endcase
        end else if (timeout) begin
            ps_next = W_HDR;
            reject  = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) ps <= W_HDR;
        else       ps <= ps_next;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            sh_h      <= '0;
            sh_m      <= '0;
            sh_s      <= '0;
            idle_cnt  <= '0;
            Hour      <= '0;
            Minute    <= '0;
            Seconds   <= '0;
            set_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            set_valid <= accept;
            frame_err <= reject;
            if (byte_ok || byte_ferr)      idle_cnt <= TW'(1);
            else if (ps == W_HDR || timeout) idle_cnt <= '0;
            else                           idle_cnt <= idle_cnt + 1'b1;
            if (byte_ok) begin
                if (ps == W_H) sh_h <= shreg;
                if (ps == W_M) sh_m <= shreg;
                if (ps == W_S) sh_s <= shreg;
            end
            if (accept) begin
                Hour    <= sh_h[4:0];
                Minute  <= sh_m[5:0];
                Seconds <= sh_s[5:0];
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_clock_set_from_pc.sv
// Bench for the UART time-set receiver: serial driver, frame-level reference model,
// and a per-cycle compare of pulses and held outputs against the model.
module tb_uart_rx_clock_set_from_pc;
    localparam int CLK_FREQ = 3_686_400;
    localparam int TO       = 5000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] baud_set = 3'd4;
    logic       uart_rx = 1'b1;
    logic [4:0] Hour;
    logic [5:0] Minute, Seconds;
    logic       set_valid, frame_err;

    uart_rx_clock_set_from_pc #(.CLK_FREQ(CLK_FREQ), .TIMEOUT_CYC(TO)) dut (
        .Clk(clk), .Reset(rst), .baud_set(baud_set), .uart_rx(uart_rx),
        .Hour(Hour), .Minute(Minute), .Seconds(Seconds),
        .set_valid(set_valid), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         acc;
        logic [4:0] h;
        logic [5:0] m;
        logic [5:0] s;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] fr[$];
    logic [4:0] mh = '0;
    logic [5:0] mm = '0, ms = '0;
    int         checks = 0, errors = 0;
    int         cyc = 0, sv_cyc = 0, err_cyc = 0, start_cyc = 0;
    bit         chk_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference model: frame-level view of the byte stream
    function automatic void push_ev(input bit acc, input logic [7:0] h, m, s);
        ev_t e;
        e.acc = acc; e.h = h[4:0]; e.m = m[5:0]; e.s = s[5:0];
        exp_q.push_back(e);
    endfunction

    function automatic void model_byte(input logic [7:0] b, input bit ferr);
        if (ferr) begin
            if (fr.size() != 0) push_ev(1'b0, 8'h0, 8'h0, 8'h0);
            fr.delete();
        end else if (fr.size() == 0) begin
            if (b == 8'hAA) fr.push_back(b);
        end else begin
            fr.push_back(b);
            if (fr.size() == 5) begin
                push_ev(fr[4] == (fr[1] ^ fr[2] ^ fr[3]) && fr[1] <= 8'd23 &&
                        fr[2] <= 8'd59 && fr[3] <= 8'd59, fr[1], fr[2], fr[3]);
                fr.delete();
            end
        end
    endfunction

    function automatic void model_timeout();
        if (fr.size() != 0) push_ev(1'b0, 8'h0, 8'h0, 8'h0);
        fr.delete();
    endfunction

    function automatic void model_reset();
        fr.delete();
        exp_q.delete();
        mh = '0; mm = '0; ms = '0;
    endfunction

    always @(negedge clk) begin
        ev_t e;
        if (chk_en) begin
            if (set_valid || frame_err) begin
                if (set_valid) sv_cyc = cyc;
                if (frame_err) err_cyc = cyc;
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", int'({set_valid, frame_err}), 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("pulse_kind", int'({set_valid, frame_err}), e.acc ? 2 : 1);
                    if (e.acc) begin mh = e.h; mm = e.m; ms = e.s; end
                end
            end
            chk("outputs", int'({Hour, Minute, Seconds}), int'({mh, mm, ms}));
        end
    end

    function automatic int div_of(input int b);
        case (b)
            0:       return CLK_FREQ / (9600 * 16);
            1:       return CLK_FREQ / (19200 * 16);
            2:       return CLK_FREQ / (38400 * 16);
            3:       return CLK_FREQ / (57600 * 16);
            default: return CLK_FREQ / (115200 * 16);
        endcase
    endfunction

    function automatic int bit_p();
        return 16 * div_of(int'(baud_set));
    endfunction

    // Called just after a posedge; leaves the caller just after a posedge
    task automatic send_byte(input logic [7:0] b, input bit stop_ok, input int gap);
        int p;
        p = bit_p();
        model_byte(b, !stop_ok);
        uart_rx = 1'b0;
        start_cyc = cyc;
        repeat (p) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (p) @(posedge clk);
        end
        uart_rx = stop_ok;
        repeat (p) @(posedge clk);
        uart_rx = 1'b1;
        repeat (gap) @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] h, m, s, c, input int gap);
        send_byte(8'hAA, 1'b1, gap);
        send_byte(h, 1'b1, gap);
        send_byte(m, 1'b1, gap);
        send_byte(s, 1'b1, gap);
        send_byte(c, 1'b1, gap);
    endtask

    task automatic set_baud(input logic [2:0] b);
        baud_set = b;
        repeat (4) @(posedge clk);
    endtask

    task automatic drain(input string name, input int lim);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < lim) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_%s: %0d expected pulses not seen within %0d cycles",
                     name, exp_q.size(), lim);
            exp_q.delete();
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic chk_out(input string name, input int h, m, s);
        chk({name, "_hour"}, int'(Hour), h);
        chk({name, "_min"}, int'(Minute), m);
        chk({name, "_sec"}, int'(Seconds), s);
    endtask

    task automatic run_random(input int n);
        logic [7:0] h, m, s, c, junk;
        int kind;
        for (int f = 0; f < n; f++) begin
            set_baud(3'($urandom_range(3, 7)));
            kind = $urandom_range(0, 5);
            h = 8'($urandom_range(0, 23));
            m = 8'($urandom_range(0, 59));
            s = 8'($urandom_range(0, 59));
            if (kind == 4) begin
                case ($urandom_range(0, 2))
                    0:       h = 8'($urandom_range(24, 255));
                    1:       m = 8'($urandom_range(60, 255));
                    default: s = 8'($urandom_range(60, 255));
                endcase
            end
            c = h ^ m ^ s;
            if (kind == 3) c = c ^ 8'($urandom_range(1, 255));
            if (kind == 5) begin
                junk = 8'($urandom_range(0, 254));
                if (junk == 8'hAA) junk = 8'h55;
                send_byte(junk, 1'b1, $urandom_range(0, 40));
            end
            send_frame(h, m, s, c, $urandom_range(0, 40));
            drain("random", 200);
        end
    endtask

    initial begin
        int d, s05, p;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        chk_en = 1'b1;
        chk_out("reset", 0, 0, 0);
        chk("reset_set_valid", int'(set_valid), 0);
        chk("reset_frame_err", int'(frame_err), 0);
        @(posedge clk);

        send_frame(8'h0C, 8'h22, 8'h38, 8'h16, 0);
        drain("valid", 200);
        d = sv_cyc - 1 - start_cyc;
        chk_out("valid", 12, 34, 56);

        send_frame(8'h0C, 8'h22, 8'h38, 8'h17, 0);
        drain("badck", 200);
        chk_out("badck", 12, 34, 56);
        send_frame(8'h01, 8'h02, 8'h03, 8'h00, 5);
        drain("recover", 200);
        chk_out("recover", 1, 2, 3);

        send_frame(8'h18, 8'h00, 8'h00, 8'h18, 0);
        drain("range", 200);
        chk_out("range", 1, 2, 3);
        send_byte(8'h55, 1'b1, 0);
        send_byte(8'h12, 1'b1, 3);
        send_frame(8'h0A, 8'h0B, 8'h0C, 8'h0D, 0);
        drain("junk", 200);
        chk_out("junk", 10, 11, 12);

        p = bit_p();
        send_byte(8'hAA, 1'b1, 0);
        send_byte(8'h02, 1'b1, 2 * p);
        uart_rx = 1'b0;
        repeat (p * 3 / 10) @(posedge clk);
        uart_rx = 1'b1;
        repeat (2 * p) @(posedge clk);
        send_byte(8'h03, 1'b1, 0);
        send_byte(8'h04, 1'b1, 0);
        send_byte(8'h05, 1'b1, 0);
        drain("glitch", 200);
        chk_out("glitch", 2, 3, 4);

        send_byte(8'hAA, 1'b1, 0);
        send_byte(8'h01, 1'b1, 0);
        send_byte(8'h02, 1'b0, 2 * p);
        drain("stoperr", 200);
        send_frame(8'h01, 8'h02, 8'h03, 8'h00, 0);
        drain("after_stoperr", 200);
        chk_out("after_stoperr", 1, 2, 3);

        send_byte(8'hAA, 1'b1, 0);
        send_byte(8'h05, 1'b1, 0);
        s05 = start_cyc;
        model_timeout();
        drain("timeout", TO + 2000);
        chk("timeout_cycle", err_cyc, s05 + d + TO);
        send_frame(8'h05, 8'h06, 8'h07, 8'h04, 0);
        drain("after_timeout", 200);
        chk_out("after_timeout", 5, 6, 7);

        send_byte(8'hAA, 1'b1, 0);
        send_byte(8'h07, 1'b1, 0);
        send_byte(8'h08, 1'b1, 4);
        chk_en = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        chk_en = 1'b1;
        chk_out("midreset", 0, 0, 0);
        repeat (20) @(posedge clk);
        chk_out("midreset_hold", 0, 0, 0);
        send_frame(8'h09, 8'h0A, 8'h0B, 8'h08, 0);
        drain("after_reset", 200);
        chk_out("after_reset", 9, 10, 11);

        set_baud(3'd0);
        send_frame(8'h0C, 8'h22, 8'h38, 8'h16, 0);
        drain("baud9600", 2000);
        chk_out("baud9600", 12, 34, 56);

        run_random(8);

        repeat (10) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
